pll_lock_manager: RTL and testbench

- Supervises an on-chip PLL from its reference-clock domain: drives the PLL reset, qualifies its locked flag and automatically recovers from loss of lock with bounded retries.
- Generates NUM_CH phase-aligned clock-enable strobes at run-time programmable divide ratios. These are the generalised replacement for fixed divided PLL outputs such as the 2 MHz slow clock.
- Strobes run only while lock is qualified.
- Sits between the PLL wrapper and downstream slow-control/housekeeping logic.

---
 rtl/pll_lock_manager_if.sv | 39 +++
 rtl/pll_lock_manager.sv | 192 +++++++++++++++++++
 tb/tb_pll_lock_manager.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_manager_if.sv
// ---------------------------------------------------------------------------
// pll_lock_manager_if
//   Bundles the PLL-side and downstream-side signals of pll_lock_manager.
//
//   master : the surrounding system (PLL wrapper, slow-control logic, bench)
//   slave  : pll_lock_manager itself
//
//   pll_locked  master->slave  PLL locked flag (asynchronous to refclk)
//   div_ratio   master->slave  NUM_CH packed divide ratios, ch k at [k*DIV_W +: DIV_W]
//   clear_fault master->slave  one-cycle pulse, leaves FAULT
//   pll_rst     slave->master  active-high PLL reset
//   ready       slave->master  lock qualified (RUN)
//   fault       slave->master  retries exhausted (FAULT)
//   ce          slave->master  per-channel one-cycle clock-enable strobes
//   relock_cnt  slave->master  saturating count of lock losses while running
// ---------------------------------------------------------------------------
interface pll_lock_manager_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  logic                      pll_locked;
  logic [NUM_CH*DIV_W-1:0]   div_ratio;
  logic                      clear_fault;
  logic                      pll_rst;
  logic                      ready;
  logic                      fault;
  logic [NUM_CH-1:0]         ce;
  logic [7:0]                relock_cnt;

  modport master (
    output pll_locked, div_ratio, clear_fault,
    input  pll_rst, ready, fault, ce, relock_cnt
  );

  modport slave (
    input  pll_locked, div_ratio, clear_fault,
    output pll_rst, ready, fault, ce, relock_cnt
  );
endinterface

// File: rtl/pll_lock_manager.sv
// ---------------------------------------------------------------------------
// pll_lock_manager
//   Supervises a PLL from its reference-clock domain: pulses the PLL reset,
//   qualifies the (synchronised) locked flag with a filter, retries on lock
//   timeout and drops to FAULT after MAX_RETRY consecutive failures. While
//   lock is qualified it produces NUM_CH phase-aligned clock-enable strobes
//   at run-time programmable divide ratios.
//
//   refclk  in  sole clock
//   rst_n   in  asynchronous active-low reset
//   bus     slave modport of pll_lock_manager_if (see interface header)
//
//   All outputs are registered; ready/fault/pll_rst/ce are derived from the
//   next state so they change in the same cycle the state does.
// ---------------------------------------------------------------------------
module pll_lock_manager #(
  parameter int NUM_CH      = 2,       // 1..8
  parameter int DIV_W       = 16,
  parameter int RST_CYC     = 16,      // >= 2
  parameter int FILT_CYC    = 1000,    // >= 1
  parameter int TIMEOUT_CYC = 100000,  // > FILT_CYC
  parameter int MAX_RETRY   = 3        // 1..255
) (
  input  logic                refclk,
  input  logic                rst_n,
  pll_lock_manager_if.slave   bus
);

  localparam int RST_W  = $clog2(RST_CYC + 1);
  localparam int FILT_W = $clog2(FILT_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_RST_PLL   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              sync1_reg, lk_reg;
  logic [RST_W-1:0]  rst_cnt_reg, rst_cnt_next;
  logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [7:0]        retry_reg, retry_next;
  logic [7:0]        relock_reg, relock_next;
  logic              pll_rst_reg, ready_reg, fault_reg;
  logic [NUM_CH-1:0] ce_vec;

  // Two-flop synchroniser for the asynchronous locked flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      lk_reg    <= 1'b0;
    end else begin
      sync1_reg <= bus.pll_locked;
      lk_reg    <= sync1_reg;
    end
  end

  // State and supervision counters.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RST_PLL;
      rst_cnt_reg  <= '0;
      filt_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      retry_reg    <= '0;
      relock_reg   <= '0;
      pll_rst_reg  <= 1'b1;
      ready_reg    <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      filt_cnt_reg <= filt_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      retry_reg    <= retry_next;
      relock_reg   <= relock_next;
      pll_rst_reg  <= (state_next == ST_RST_PLL) || (state_next == ST_FAULT);
      ready_reg    <= (state_next == ST_RUN);
      fault_reg    <= (state_next == ST_FAULT);
    end
  end

  // Next-state logic. Counters default to zero so each one restarts from
  // zero whenever its state is (re)entered.
  always_comb begin
    state_next    = state_reg;
    rst_cnt_next  = '0;
    filt_cnt_next = '0;
    to_cnt_next   = '0;
    retry_next    = retry_reg;
    relock_next   = relock_reg;
    case (state_reg)
      ST_RST_PLL: begin
        if (rst_cnt_reg == RST_W'(RST_CYC - 1)) begin
          state_next = ST_WAIT_LOCK;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Filter completion is tested first so it wins over a coincident timeout.
        if (lk_reg && (filt_cnt_reg == FILT_W'(FILT_CYC - 1))) begin
          state_next = ST_RUN;
          retry_next = '0;
        end else if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
          retry_next = retry_reg + 8'd1;
          if ((9'(retry_reg) + 9'd1) < 9'(MAX_RETRY)) begin
            state_next = ST_RST_PLL;
          end else begin
            state_next = ST_FAULT;
          end
        end else begin
          filt_cnt_next = lk_reg ? (filt_cnt_reg + FILT_W'(1)) : '0;
          to_cnt_next   = to_cnt_reg + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (!lk_reg) begin
          state_next = ST_RST_PLL;
          if (relock_reg != 8'hFF) begin
            relock_next = relock_reg + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault) begin
          state_next  = ST_RST_PLL;
          retry_next  = '0;
          relock_next = '0;
        end
      end
      default: state_next = ST_RST_PLL;
    endcase
  end

  // Clock-enable dividers. Every channel restarts at zero on RUN entry, which
  // gives all channels the same phase origin. The ratio is re-sampled only at
  // a period boundary (RUN entry or the cycle after a strobe), so a ratio
  // change never truncates or stretches the period in progress.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] ratio;
      logic [DIV_W-1:0] rk_reg, rk_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             ce_reg, ce_next;

      assign ratio = bus.div_ratio[gi*DIV_W +: DIV_W];

      always_comb begin
        rk_next  = rk_reg;
        cnt_next = '0;
        ce_next  = 1'b0;
        // Gating on the next state suppresses a strobe that coincides with
        // lock loss.
        if (state_next == ST_RUN) begin
          if ((state_reg != ST_RUN) || ce_reg) begin
            rk_next  = ratio;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + DIV_W'(1);
          end
          // Ratios 0 and 1 both mean "strobe every cycle".
          ce_next = (rk_next <= DIV_W'(1)) || (cnt_next == (rk_next - DIV_W'(1)));
        end
      end

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          rk_reg  <= '0;
          cnt_reg <= '0;
          ce_reg  <= 1'b0;
        end else begin
          rk_reg  <= rk_next;
          cnt_reg <= cnt_next;
          ce_reg  <= ce_next;
        end
      end

      assign ce_vec[gi] = ce_reg;
    end
  endgenerate

  assign bus.pll_rst    = pll_rst_reg;
  assign bus.ready      = ready_reg;
  assign bus.fault      = fault_reg;
  assign bus.ce         = ce_vec;
  assign bus.relock_cnt = relock_reg;

endmodule

// File: tb/tb_pll_lock_manager.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_manager
//   Directed sequence with randomised ratios and event times. A simple PLL
//   model drops its locked flag while pll_rst is high. Expected strobe times
//   are predicted arithmetically: each channel's next strobe lies one
//   effective ratio after the previous one, with the ratio taken at the
//   period boundary.
// ---------------------------------------------------------------------------
module tb_pll_lock_manager;
  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 16;
  localparam int RST_CYC     = 16;
  localparam int FILT_CYC    = 8;
  localparam int TIMEOUT_CYC = 50;
  localparam int MAX_RETRY   = 3;
  localparam int SYNC_LAT    = 2;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  logic lock_src;

  always #5 refclk = ~refclk;

  pll_lock_manager_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  // PLL model: locked only while not held in reset and the source is good.
  assign bus.pll_locked = lock_src & ~bus.pll_rst;

  pll_lock_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYC(RST_CYC), .FILT_CYC(FILT_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int run_n;
  int next_ce [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DIV_W-1:0] ratio_of(input int k);
    return bus.div_ratio[k*DIV_W +: DIV_W];
  endfunction

  function automatic int eff(input logic [DIV_W-1:0] r);
    return (r <= 1) ? 1 : int'(r);
  endfunction

  // Called at the negedge of the first RUN cycle.
  task automatic run_start();
    run_n = 0;
    for (int k = 0; k < NUM_CH; k++) next_ce[k] = eff(ratio_of(k));
  endtask

  // Checks the current RUN cycle, then schedules the next strobe using the
  // ratio that will be sampled at the coming boundary.
  task automatic check_cycle();
    bit e;
    run_n++;
    chk($sformatf("ready_run%0d", run_n), 32'(bus.ready), 32'd1);
    for (int k = 0; k < NUM_CH; k++) begin
      e = (run_n == next_ce[k]);
      chk($sformatf("ce%0d_run%0d", k, run_n), 32'(bus.ce[k]), 32'(e));
      if (e) next_ce[k] += eff(ratio_of(k));
    end
  endtask

  task automatic check_run(input int n);
    repeat (n) begin
      @(negedge refclk);
      check_cycle();
    end
  endtask

  task automatic meas_rst(output int n);
    n = 0;
    while (bus.pll_rst === 1'b1 && n < 500) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic meas_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 500) begin
      @(negedge refclk);
      n++;
    end
  endtask

  // Single-cycle lock drop in RUN; ends at the negedge where loss is visible.
  task automatic lock_drop(input bit permanent);
    @(negedge refclk);
    lock_src = 1'b0;
    check_cycle();
    @(negedge refclk);
    if (!permanent) lock_src = 1'b1;
    check_cycle();
    @(negedge refclk);
    check_cycle();
    @(negedge refclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pll_rst"}, 32'(bus.pll_rst), 32'd1);
    chk({tag, "_ready"},   32'(bus.ready),   32'd0);
    chk({tag, "_fault"},   32'(bus.fault),   32'd0);
    chk({tag, "_ce"},      32'(bus.ce),      32'd0);
    chk({tag, "_relock"},  32'(bus.relock_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int falls;
    int chg;
    logic prev;

    lock_src        = 1'b1;
    bus.clear_fault = 1'b0;
    bus.div_ratio   = {16'd5, 16'd1};

    // Reset state.
    repeat (3) @(negedge refclk);
    chk_reset_outputs("reset");
    $display("step reset: outputs at reset values");

    // Power-up.
    rst_n = 1'b1;
    meas_rst(n);
    chk("pwrup_rst_len", n, RST_CYC);
    chk("pwrup_fault", 32'(bus.fault), 32'd0);
    meas_ready(n);
    chk("pwrup_ready_lat", n, FILT_CYC + SYNC_LAT);
    $display("step power-up: ready after %0d cycles", n);

    // Dividers {5,1}, then ch1 -> 3 somewhere in the third period.
    run_start();
    check_cycle();
    check_run(11);
    chg = $urandom_range(0, 2);
    for (int i = 0; i < 30; i++) begin
      @(negedge refclk);
      if (i == chg) bus.div_ratio[DIV_W +: DIV_W] = 16'd3;
      check_cycle();
    end
    $display("step dividers: ch1 ratio changed at run cycle %0d", 13 + chg);

    // Single-cycle lock glitch; ch0 strobes every cycle so the loss cycle
    // also checks strobe suppression.
    check_run($urandom_range(1, 6));
    lock_drop(1'b0);
    chk("glitch_ready", 32'(bus.ready), 32'd0);
    chk("glitch_ce", 32'(bus.ce), 32'd0);
    chk("glitch_pll_rst", 32'(bus.pll_rst), 32'd1);
    chk("glitch_relock", 32'(bus.relock_cnt), 32'd1);
    bus.div_ratio = {16'($urandom_range(2, 9)), 16'($urandom_range(0, 3))};
    meas_rst(n);
    chk("glitch_rst_len", n, RST_CYC);
    meas_ready(n);
    chk("glitch_ready_lat", n, FILT_CYC + SYNC_LAT);
    run_start();
    check_cycle();
    check_run(25);
    chk("glitch_relock_hold", 32'(bus.relock_cnt), 32'd1);
    $display("step glitch: relocked with ratios ch0=%0d ch1=%0d", ratio_of(0), ratio_of(1));

    // Filter chatter in WAIT_LOCK: 5-cycle windows never qualify.
    lock_drop(1'b0);
    chk("chatter_relock", 32'(bus.relock_cnt), 32'd2);
    chk("chatter_ready0", 32'(bus.ready), 32'd0);
    bus.div_ratio = {16'hFFFF, 16'd0};
    meas_rst(n);
    chk("chatter_rst_len", n, RST_CYC);
    for (int i = 0; i < 30; i++) begin
      lock_src = ((i / 5) % 2 == 0);
      chk($sformatf("chatter_ready_c%0d", i), 32'(bus.ready), 32'd0);
      @(negedge refclk);
    end
    lock_src = 1'b1;
    meas_ready(n);
    chk("chatter_ready_lat", n, FILT_CYC + SYNC_LAT);
    run_start();
    check_cycle();
    check_run(20);
    $display("step chatter: lock qualified %0d cycles after settling", n);

    // Permanent loss: retries then FAULT; a stray clear_fault is ignored.
    lock_drop(1'b1);
    chk("retry_relock", 32'(bus.relock_cnt), 32'd3);
    chk("retry_pll_rst", 32'(bus.pll_rst), 32'd1);
    n = 0;
    falls = 0;
    prev = bus.pll_rst;
    while (bus.fault !== 1'b1 && n < 1000) begin
      @(negedge refclk);
      n++;
      if (n == 20) bus.clear_fault = 1'b1;
      if (n == 21) bus.clear_fault = 1'b0;
      if (prev === 1'b1 && bus.pll_rst === 1'b0) falls++;
      prev = bus.pll_rst;
    end
    chk("fault_latency", n, MAX_RETRY * (RST_CYC + TIMEOUT_CYC));
    chk("fault_attempts", falls, MAX_RETRY);
    chk("fault_relock", 32'(bus.relock_cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fault_hold%0d", i), {29'd0, bus.fault, bus.pll_rst, bus.ready}, 32'b110);
      @(negedge refclk);
    end
    $display("step fault: FAULT after %0d cycles, %0d attempts", n, falls);

    // clear_fault restarts with retry and relock_cnt cleared.
    bus.div_ratio   = {16'd2, 16'd5};
    bus.clear_fault = 1'b1;
    lock_src        = 1'b1;
    @(negedge refclk);
    bus.clear_fault = 1'b0;
    chk("clear_fault", 32'(bus.fault), 32'd0);
    chk("clear_pll_rst", 32'(bus.pll_rst), 32'd1);
    chk("clear_relock", 32'(bus.relock_cnt), 32'd0);
    meas_rst(n);
    chk("clear_rst_len", n, RST_CYC);
    meas_ready(n);
    chk("clear_ready_lat", n, FILT_CYC + SYNC_LAT);
    run_start();
    check_cycle();
    check_run(7);
    $display("step clear: RUN resumed after clear_fault");

    // Asynchronous reset pulse inside one clock phase.
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    #1 rst_n = 1'b1;
    meas_rst(n);
    chk("async_rst_len", n, RST_CYC);
    meas_ready(n);
    chk("async_ready_lat", n, FILT_CYC + SYNC_LAT);
    run_start();
    check_cycle();
    check_run(12);
    $display("step async reset: power-up sequence repeated");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
